// File: rtl/unsigned_16by8_seq_div_pkg.sv
// Shared types, default widths and a behavioural reference for the sequential divider.
package unsigned_16by8_seq_div_pkg;

    localparam int DW_N_DEF = 16;
    localparam int DW_D_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [DW_N_DEF-1:0] q;
        logic [DW_D_DEF-1:0] r;
        logic                dbz;
    } div_res_t;

    // Divide-by-zero convention: all-ones quotient, zero remainder, flag set.
    function automatic div_res_t div_ref(input logic [DW_N_DEF-1:0] n,
                                         input logic [DW_D_DEF-1:0] d);
        div_res_t res;
        if (d == '0) begin
            res.q   = '1;
            res.r   = '0;
            res.dbz = 1'b1;
        end else begin
            res.q   = n / DW_N_DEF'(d);
            res.r   = DW_D_DEF'(n % DW_N_DEF'(d));
            res.dbz = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/unsigned_16by8_seq_div_if.sv
// Operand/result valid-ready bus; master is the client, slave is the divider.
interface unsigned_16by8_seq_div_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/unsigned_16by8_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int DW_D = 8
) (
    input  logic [DW_D:0]   i_prem,
    input  logic            i_msb,
    input  logic [DW_D-1:0] i_divisor,
    output logic [DW_D:0]   o_prem,
    output logic            o_qbit
);
    logic [DW_D+1:0] w_diff;

    // Extra top bit acts as the borrow: set means the trial went negative.
    assign w_diff = {i_prem, i_msb} - {2'b00, i_divisor};
    assign o_qbit = ~w_diff[DW_D+1];
    assign o_prem = o_qbit ? w_diff[DW_D:0] : {i_prem[DW_D-1:0], i_msb};

endmodule

// File: rtl/unsigned_16by8_seq_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
module unsigned_16by8_seq_div
    import unsigned_16by8_seq_div_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    unsigned_16by8_seq_div_if.slave  bus
);
    localparam int CW = $clog2(DW_N + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW_N-1:0] r_dvd;
    logic [DW_D-1:0] r_dvs;
    logic [DW_D:0]   r_prem;
    logic [DW_N-1:0] r_quo;
    logic [DW_D-1:0] r_rem;
    logic            r_dbz;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [DW_D:0]   w_prem;
    logic            w_qbit;

    div_restore_step #(.DW_D(DW_D)) u_step (
        .i_prem    (r_prem),
        .i_msb     (r_dvd[DW_N-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_quo       <= '1;
                            r_rem       <= '0;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd   <= bus.dividend;
                            r_dvs   <= bus.divisor;
                            r_prem  <= '0;
                            r_quo   <= '0;
                            r_dbz   <= 1'b0;
                            r_cnt   <= CW'(DW_N);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_prem <= w_prem;
                    r_dvd  <= r_dvd << 1;
                    r_quo  <= {r_quo[DW_N-2:0], w_qbit};
                    r_cnt  <= r_cnt - 1'b1;
                    // Count of 1 means this edge commits the last quotient bit.
                    if (r_cnt == CW'(1)) begin
                        r_rem       <= w_prem[DW_D-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Directed-vector bench for the sequential divider, plus a short reference-checked random run.
module tb_unsigned_16by8_seq_div;
    import unsigned_16by8_seq_div_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    unsigned_16by8_seq_div_if #(.DW_N(16), .DW_D(8)) dif ();

    unsigned_16by8_seq_div #(.DW_N(16), .DW_D(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction: accept, measure latency, hold DONE for 'hold' cycles, then drain.
    task automatic do_op(input string tag, input logic [15:0] n, input logic [7:0] d,
                         input int hold, input logic [15:0] eq, input logic [7:0] er,
                         input logic edbz, input int elat,
                         output logic [15:0] oq, output logic [7:0] orem);
        int   k;
        int   lat;
        logic busy_bad;
        logic hold_bad;
        k = 0;
        while (!dif.in_ready && k < 50) begin
            tick();
            k++;
        end
        chk({tag, "_in_ready_idle"}, 32'(dif.in_ready), 32'd1);
        dif.out_ready = (hold == 0);
        dif.in_valid  = 1'b1;
        dif.dividend  = n;
        dif.divisor   = d;
        tick();
        dif.in_valid = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 8'($urandom);
        chk({tag, "_dbz_at_accept"}, 32'(dif.div_by_zero), 32'(edbz));
        lat = 1;
        busy_bad = 1'b0;
        while (!dif.out_valid && lat < 40) begin
            if (dif.in_ready) busy_bad = 1'b1;
            dif.in_valid = 1'b1;
            tick();
            dif.in_valid = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_in_ready_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_quotient"}, 32'(dif.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(dif.remainder), 32'(er));
        chk({tag, "_div_by_zero"}, 32'(dif.div_by_zero), 32'(edbz));
        oq   = dif.quotient;
        orem = dif.remainder;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!dif.out_valid || dif.in_ready || dif.quotient !== eq ||
                dif.remainder !== er || dif.div_by_zero !== edbz)
                hold_bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
        dif.out_ready = 1'b1;
        tick();
        chk({tag, "_out_valid_drop"}, 32'(dif.out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(dif.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic [15:0] n;
        logic [7:0]  d;
        logic        seen;
        div_res_t    ref_res;
        int          sel;

        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_quotient", 32'(dif.quotient), 32'd0);
        chk("rst_remainder", 32'(dif.remainder), 32'd0);
        chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("d50000_200", 16'd50000, 8'd200, 0, 16'd250, 8'd0, 1'b0, 17, q, r);
        do_op("d65535_1", 16'd65535, 8'd1, 0, 16'd65535, 8'd0, 1'b0, 17, q, r);
        do_op("d100_255", 16'd100, 8'd255, 0, 16'd0, 8'd100, 1'b0, 17, q, r);
        do_op("d1234_0", 16'd1234, 8'd0, 0, 16'hFFFF, 8'd0, 1'b1, 1, q, r);
        do_op("d7_3", 16'd7, 8'd3, 0, 16'd2, 8'd1, 1'b0, 17, q, r);
        do_op("d40000_7", 16'd40000, 8'd7, 10, 16'd5714, 8'd2, 1'b0, 17, q, r);
        do_op("d0_5", 16'd0, 8'd5, 0, 16'd0, 8'd0, 1'b0, 17, q, r);
        do_op("d255_255", 16'd255, 8'd255, 0, 16'd1, 8'd0, 1'b0, 17, q, r);
        do_op("d65535_255", 16'd65535, 8'd255, 2, 16'd257, 8'd0, 1'b0, 17, q, r);
        do_op("d65535_254", 16'd65535, 8'd254, 0, 16'd258, 8'd3, 1'b0, 17, q, r);
        do_op("d1000_7", 16'd1000, 8'd7, 1, 16'd142, 8'd6, 1'b0, 17, q, r);

        // Reset in the middle of a RUN must discard the result silently.
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.dividend  = 16'd60000;
        dif.divisor   = 8'd13;
        tick();
        dif.in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("midrst_quotient", 32'(dif.quotient), 32'd0);
        chk("midrst_remainder", 32'(dif.remainder), 32'd0);
        chk("midrst_dbz", 32'(dif.div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (dif.out_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            if (dif.out_valid) seen = 1'b1;
        end
        chk("midrst_no_out_valid", 32'(seen), 32'd0);
        do_op("d60000_13", 16'd60000, 8'd13, 0, 16'd4615, 8'd5, 1'b0, 17, q, r);

        for (int i = 0; i < 300; i++) begin
            n   = 16'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      d = 8'd0;
            else if (sel == 1) d = 8'd255;
            else if (sel == 2) d = 8'd1;
            else               d = 8'($urandom);
            ref_res = div_ref(n, d);
            do_op("rnd", n, d, int'($urandom_range(0, 3)), ref_res.q, ref_res.r,
                  ref_res.dbz, (d == 8'd0) ? 1 : 17, q, r);
            if (d != 8'd0)
                chk("rnd_invariant", 32'(q) * 32'(d) + 32'(r), 32'(n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
